spm_seq_ctrl: RTL

- Sequencer for the sparse ternary polynomial multiplier (sum_one / sum_mone accumulator datapath, LAC, n=512, 8-bit coefficients).
- Scans the ternary polynomial r from a synchronous read memory, skips zero coefficients, and issues one command per nonzero coefficient (index, sign) to the accumulator datapath over a valid/ready handshake.
- Owns start/busy/done for a whole multiplication and reports the count of +1 and -1 coefficients.

---
 rtl/spm_seq_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the sparse ternary multiplier: scans r, skips zeros,
// and issues one (index, sign) command per nonzero coefficient.
module spm_seq_ctrl #(
   parameter int N  = 512,
   parameter int AW = 9,
   parameter int CW = 10
) (
   input  logic          i_clock,
   input  logic          i_reset,
   input  logic          i_start,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_r_rd_en,
   output logic [AW-1:0] o_r_addr,
   input  logic [1:0]    i_r_data,
   output logic          o_cmd_valid,
   input  logic          i_cmd_ready,
   output logic [AW-1:0] o_cmd_idx,
   output logic          o_cmd_neg,
   input  logic          i_dp_idle,
   output logic [CW-1:0] o_cnt_one,
   output logic [CW-1:0] o_cnt_mone,
   output logic          o_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q;
   logic          rd_last_q;
   logic          infl_q;
   logic [AW-1:0] infl_addr_q;
   logic [AW-1:0] fifo_idx_q [2];
   logic [1:0]    fifo_neg_q;
   logic          wr_ptr_q;
   logic          rd_ptr_q;
   logic [1:0]    fifo_cnt_q;
   logic [CW-1:0] cnt_one_q;
   logic [CW-1:0] cnt_mone_q;
   logic          err_q;

   logic          start;
   logic          rd_en;
   logic          push;
   logic          pop;
   logic          illegal;
   logic          fifo_empty;
   logic [2:0]    occ;

   // occ is the FIFO plus in-flight load after this cycle's pop,
   // which lets reads stream at one per cycle without overflow.
   always_comb begin
      fifo_empty = (fifo_cnt_q == 2'd0);
      pop        = !fifo_empty && i_cmd_ready;
      push       = infl_q && i_r_data[0];
      illegal    = infl_q && (i_r_data == 2'b10);
      occ        = {1'b0, fifo_cnt_q} + {2'b00, infl_q}
                 - {2'b00, pop};
      start      = (state_q == S_IDLE) && i_start;
      rd_en      = (state_q == S_SCAN) && !rd_last_q
                 && (occ < 3'd2);
   end

   always_comb begin
      state_d = state_q;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_start)
               state_d = S_SCAN;
         end
         S_SCAN: begin
            o_busy = 1'b1;
            if (rd_last_q && !infl_q &&
                (fifo_empty || (fifo_cnt_q == 2'd1 && pop)))
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            o_busy = 1'b1;
            if (i_dp_idle)
               state_d = S_DONE;
         end
         S_DONE: begin
            o_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         rd_last_q   <= 1'b0;
         infl_q      <= 1'b0;
         infl_addr_q <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         fifo_cnt_q  <= 2'd0;
         cnt_one_q   <= '0;
         cnt_mone_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         infl_q  <= rd_en;
         if (rd_en) begin
            infl_addr_q <= addr_q;
            if (addr_q == LAST_ADDR)
               rd_last_q <= 1'b1;
            else
               addr_q <= addr_q + AW'(1);
         end
         if (push)
            wr_ptr_q <= !wr_ptr_q;
         if (pop)
            rd_ptr_q <= !rd_ptr_q;
         fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
         if (illegal)
            err_q <= 1'b1;
         if (pop) begin
            if (fifo_neg_q[rd_ptr_q]) begin
               if (cnt_mone_q != CNT_MAX)
                  cnt_mone_q <= cnt_mone_q + CW'(1);
            end else begin
               if (cnt_one_q != CNT_MAX)
                  cnt_one_q <= cnt_one_q + CW'(1);
            end
         end
         if (start) begin
            addr_q     <= '0;
            rd_last_q  <= 1'b0;
            cnt_one_q  <= '0;
            cnt_mone_q <= '0;
            err_q      <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (push) begin
         fifo_idx_q[wr_ptr_q] <= infl_addr_q;
         fifo_neg_q[wr_ptr_q] <= i_r_data[1];
      end
   end

   assign o_r_rd_en   = rd_en;
   assign o_r_addr    = addr_q;
   assign o_cmd_valid = !fifo_empty;
   assign o_cmd_idx   = fifo_idx_q[rd_ptr_q];
   assign o_cmd_neg   = fifo_neg_q[rd_ptr_q];
   assign o_cnt_one   = cnt_one_q;
   assign o_cnt_mone  = cnt_mone_q;
   assign o_err       = err_q;

endmodule
